// File: rtl/gray_pkg.sv
// Shared helpers for gray-coded pointer crossings.
// Used by both the write-side counter and the read-side receiver.
package gray_pkg;

    localparam int PTR_MAX = 32;

    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_GRAY      = 1;
    localparam int ERR_OVERFLOW  = 2;
    localparam int ERR_W         = 3;

    function automatic logic [PTR_MAX-1:0] bin2gray(
        input logic [PTR_MAX-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Callers zero-extend, so the unused upper bits decode to zero.
    function automatic logic [PTR_MAX-1:0] gray2bin(
        input logic [PTR_MAX-1:0] g
    );
        logic [PTR_MAX-1:0] b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int popcount(
        input logic [PTR_MAX-1:0] v
    );
        int n;
        n = 0;
        for (int i = 0; i < PTR_MAX; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-bit flop-chain synchronizer for gray-coded buses.
// Reusable in either clock domain.
module gray_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [WIDTH-1:0] stage [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < N; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[N-1];

endmodule

// File: rtl/gray_receiver.sv
// Read-domain end of a gray pointer crossing: sync, decode,
// read pointer, empty/occupancy and sticky error flags.
module gray_receiver
    import gray_pkg::*;
#(
    parameter int LENGTH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_diff,
    input  logic              reset_diff,
    input  logic [LENGTH-1:0] gray_in,
    input  logic              rd_en,
    output logic              rd_ack,
    output logic [LENGTH-2:0] rd_addr,
    output logic              empty,
    output logic [LENGTH-1:0] count,
    output logic [LENGTH-1:0] gray_rd_out,
    output logic [ERR_W-1:0]  error
);

    localparam logic [LENGTH-1:0] HALF = {1'b1, {(LENGTH-1){1'b0}}};

    logic [LENGTH-1:0] gsync;
    logic [LENGTH-1:0] gprev;
    logic [LENGTH-1:0] wr_bin;
    logic [LENGTH-1:0] wr_dec;
    logic [LENGTH-1:0] rd_bin;
    logic [LENGTH-1:0] rd_next;
    logic              pop;
    logic              underflow;
    logic              jump;
    logic              overflow;

    gray_sync #(
        .WIDTH  (LENGTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk_diff),
        .rst (reset_diff),
        .d   (gray_in),
        .q   (gsync)
    );

    always_comb begin
        wr_dec    = LENGTH'(gray2bin(PTR_MAX'(gsync)));
        rd_next   = rd_bin + LENGTH'(1);
        empty     = (wr_bin == rd_bin);
        count     = wr_bin - rd_bin;
        pop       = rd_en & ~empty;
        underflow = rd_en & empty;
        jump      = popcount(PTR_MAX'(gsync ^ gprev)) > 1;
        overflow  = count > HALF;
        rd_addr   = rd_bin[LENGTH-2:0];
    end

    always_ff @(posedge clk_diff or posedge reset_diff) begin
        if (reset_diff) begin
            wr_bin <= '0;
            gprev  <= '0;
        end else begin
            wr_bin <= wr_dec;
            gprev  <= gsync;
        end
    end

    always_ff @(posedge clk_diff or posedge reset_diff) begin
        if (reset_diff) begin
            rd_bin      <= '0;
            gray_rd_out <= '0;
            rd_ack      <= 1'b0;
        end else begin
            rd_ack <= pop;
            if (pop) begin
                rd_bin      <= rd_next;
                gray_rd_out <= LENGTH'(bin2gray(PTR_MAX'(rd_next)));
            end
        end
    end

    // Flags are sticky until the next reset.
    always_ff @(posedge clk_diff or posedge reset_diff) begin
        if (reset_diff) begin
            error <= '0;
        end else begin
            if (underflow) error[ERR_UNDERFLOW] <= 1'b1;
            if (jump)      error[ERR_GRAY]      <= 1'b1;
            if (overflow)  error[ERR_OVERFLOW]  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gray_receiver.sv
// Directed-vector bench for gray_receiver
// at LENGTH=8, SYNC_STAGES=2.
module tb_gray_receiver;

    logic       clk_diff;
    logic       reset_diff;
    logic [7:0] gray_in;
    logic       rd_en;
    logic       rd_ack;
    logic [6:0] rd_addr;
    logic       empty;
    logic [7:0] count;
    logic [7:0] gray_rd_out;
    logic [2:0] error;

    int checks;
    int errors;

    gray_receiver #(
        .LENGTH      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_diff    (clk_diff),
        .reset_diff  (reset_diff),
        .gray_in     (gray_in),
        .rd_en       (rd_en),
        .rd_ack      (rd_ack),
        .rd_addr     (rd_addr),
        .empty       (empty),
        .count       (count),
        .gray_rd_out (gray_rd_out),
        .error       (error)
    );

    initial clk_diff = 1'b0;
    always #5 clk_diff = ~clk_diff;

    function automatic logic [7:0] g(input int v);
        logic [7:0] b;
        b = v[7:0];
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge clk_diff);
        #1;
    endtask

    task automatic do_reset();
        gray_in    = 8'h00;
        rd_en      = 1'b0;
        reset_diff = 1'b1;
        step();
        step();
        reset_diff = 1'b0;
        step();
    endtask

    task automatic test_reset();
        gray_in = 8'h00;
        rd_en   = 1'b0;
        #2;
        reset_diff = 1'b1;
        #1;
        checks++;
        if (error !== 3'b000 || rd_addr !== 7'd0 || count !== 8'd0) begin
            $display("FAIL reset_regs got err=%b addr=%0d cnt=%0d want 0/0/0",
                     error, rd_addr, count);
            errors++;
        end
        checks++;
        if (empty !== 1'b1 || rd_ack !== 1'b0 || gray_rd_out !== 8'h00) begin
            $display("FAIL reset_flags got empty=%b ack=%b grd=%h want 1/0/00",
                     empty, rd_ack, gray_rd_out);
            errors++;
        end
        step();
        reset_diff = 1'b0;
        step();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            gray_in = g(i);
            step();
            if (i < 3) begin
                checks++;
                if (empty !== 1'b1) begin
                    $display("FAIL fill_early_empty i=%0d got %b want 1", i, empty);
                    errors++;
                end
            end else begin
                checks++;
                if (empty !== 1'b0 || count !== 8'(i - 2)) begin
                    $display("FAIL fill_count i=%0d got empty=%b cnt=%0d want 0/%0d",
                             i, empty, count, i - 2);
                    errors++;
                end
            end
        end
        step();
        step();
        checks++;
        if (count !== 8'd5) begin
            $display("FAIL fill_final got %0d want 5", count);
            errors++;
        end
    endtask

    task automatic test_drain_underflow();
        int acks;
        acks  = 0;
        rd_en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (rd_ack !== (k <= 5)) begin
                $display("FAIL drain_ack k=%0d got %b want %b", k, rd_ack, k <= 5);
                errors++;
            end
            if (rd_ack === 1'b1) acks++;
        end
        rd_en = 1'b0;
        checks++;
        if (acks !== 5) begin
            $display("FAIL drain_acks got %0d want 5", acks);
            errors++;
        end
        checks++;
        if (gray_rd_out !== 8'h07 || rd_addr !== 7'd5 || empty !== 1'b1) begin
            $display("FAIL drain_state got grd=%h addr=%0d empty=%b want 07/5/1",
                     gray_rd_out, rd_addr, empty);
            errors++;
        end
        checks++;
        if (error !== 3'b001) begin
            $display("FAIL underflow got %b want 001", error);
            errors++;
        end
        step();
        checks++;
        if (error !== 3'b001 || rd_ack !== 1'b0) begin
            $display("FAIL underflow_sticky got err=%b ack=%b want 001/0",
                     error, rd_ack);
            errors++;
        end
    endtask

    task automatic test_wrap();
        int acks;
        do_reset();
        for (int i = 1; i <= 250; i++) begin
            gray_in = g(i);
            step();
            rd_en = ~empty;
        end
        for (int k = 0; k < 6; k++) begin
            step();
            rd_en = ~empty;
        end
        rd_en = 1'b0;
        checks++;
        if (rd_addr !== 7'd122 || gray_rd_out !== 8'h87 || error !== 3'b000) begin
            $display("FAIL wrap_pre got addr=%0d grd=%h err=%b want 122/87/000",
                     rd_addr, gray_rd_out, error);
            errors++;
        end
        for (int i = 251; i <= 260; i++) begin
            gray_in = g(i);
            step();
        end
        step();
        step();
        checks++;
        if (count !== 8'd10 || empty !== 1'b0) begin
            $display("FAIL wrap_count got cnt=%0d empty=%b want 10/0", count, empty);
            errors++;
        end
        acks  = 0;
        rd_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (rd_ack === 1'b1) acks++;
        end
        rd_en = 1'b0;
        checks++;
        if (acks !== 10) begin
            $display("FAIL wrap_acks got %0d want 10", acks);
            errors++;
        end
        checks++;
        if (rd_addr !== 7'd4 || empty !== 1'b1 || error !== 3'b000
            || gray_rd_out !== 8'h06) begin
            $display("FAIL wrap_end got addr=%0d empty=%b err=%b grd=%h want 4/1/000/06",
                     rd_addr, empty, error, gray_rd_out);
            errors++;
        end
    endtask

    task automatic test_gray_jump();
        do_reset();
        gray_in = 8'h03;
        step();
        step();
        checks++;
        if (error !== 3'b000) begin
            $display("FAIL jump_early got %b want 000", error);
            errors++;
        end
        step();
        checks++;
        if (error !== 3'b010) begin
            $display("FAIL jump_set got %b want 010", error);
            errors++;
        end
        gray_in = 8'h02;
        repeat (4) step();
        checks++;
        if (error !== 3'b010 || count !== 8'd3) begin
            $display("FAIL jump_sticky got err=%b cnt=%0d want 010/3", error, count);
            errors++;
        end
        reset_diff = 1'b1;
        #1;
        checks++;
        if (error !== 3'b000) begin
            $display("FAIL jump_clear got %b want 000", error);
            errors++;
        end
        gray_in = 8'h00;
        step();
        reset_diff = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 129; i++) begin
            gray_in = g(i);
            step();
        end
        step();
        checks++;
        if (count !== 8'd128 || error !== 3'b000) begin
            $display("FAIL ovf_edge got cnt=%0d err=%b want 128/000", count, error);
            errors++;
        end
        step();
        checks++;
        if (count !== 8'd129 || error !== 3'b000) begin
            $display("FAIL ovf_count got cnt=%0d err=%b want 129/000", count, error);
            errors++;
        end
        step();
        checks++;
        if (error !== 3'b100) begin
            $display("FAIL ovf_flag got %b want 100", error);
            errors++;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_diff = 1'b0;
        gray_in    = 8'h00;
        rd_en      = 1'b0;
        test_reset();
        test_fill();
        test_drain_underflow();
        test_reset();
        test_wrap();
        test_gray_jump();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_receiver.md
# gray_receiver

Receiving end of the gray-coded pointer crossing produced by the write-side gray counter. Samples the write-side gray count through its own synchronizer, decodes it to binary, and tracks the local read pointer. Provides empty, occupancy, a pop handshake and a registered gray read pointer that is sent back to the write domain. Sits in the read domain of every dual-clock buffer in the design.

## Interface
- LENGTH, 8, pointer width including wrap bit; address width is LENGTH-1
- SYNC_STAGES, 2, synchronizer depth on gray_in; legal range 2..4
- clk_diff  in  1  read-domain clock
- reset_diff  in  1  asynchronous, active-high reset
- gray_in  in  LENGTH  write-side gray count, asynchronous to clk_diff, changes at most one bit per write clock
- rd_en  in  1  request to consume one entry
- rd_ack  out  1  registered one-cycle pulse, pop accepted
- rd_addr  out  LENGTH-1  binary read pointer, low bits (buffer read address)
- empty  out  1  no entry available
- count  out  LENGTH  occupancy, write pointer minus read pointer
- gray_rd_out  out  LENGTH  gray code of read pointer, registered, for synchronization into the write domain
- error  out  3  sticky flags: [0] underflow, [1] gray multi-bit jump, [2] overflow

## Operation
- Reset (asynchronous, immediate): sync stages, wr_bin, rd_bin, gray_rd_out, rd_ack, error all 0. empty=1, count=0, rd_addr=0.
- Sync: gray_in passes through SYNC_STAGES flops; last stage is gsync.
- Decode: wr_bin[LENGTH-1]=gsync[LENGTH-1]; wr_bin[i]=wr_bin[i+1]^gsync[i]; result registered into wr_bin. The same edge registers gprev<=gsync.
- empty = (wr_bin == rd_bin); count = (wr_bin - rd_bin) mod 2^LENGTH; both combinational from registers.
- Pop: rd_en=1 and empty=0 at an edge -> rd_bin<=rd_bin+1, gray_rd_out<=gray(rd_bin+1), rd_ack<=1. Otherwise rd_bin is held and rd_ack<=0.
- rd_en=1 with empty=1 -> no pop, no ack, error[0]<=1.
- popcount(gsync ^ gprev) > 1 -> error[1]<=1.
- count > 2^(LENGTH-1) -> error[2]<=1.
- Error bits are cleared only by reset_diff.
- Wrap: pointers wrap modulo 2^LENGTH. The modular count stays correct across wrap.

## Timing
- gray_in stable before edge 1 -> wr_bin updated at edge SYNC_STAGES+1. empty/count reflect it after that edge (3 cycles at default).
- Pop latency: rd_bin, rd_addr, gray_rd_out and rd_ack all update on the same edge that accepts rd_en. The pop count shows in count immediately after that edge.
- rd_en held high drains one entry per cycle with no bubbles.
- Write update and pop on the same edge: empty is evaluated on pre-edge registers, so the pop is accepted if and only if the pre-edge empty=0. Both pointers update, so count changes by (write delta - 1).
- Reset asserted mid-operation: all state clears immediately. The write side must reset concurrently. A nonzero gsync after release may set error[1], and this is permitted.

## Structure
- Shared package gray_pkg holds:
  - functions bin2gray, gray2bin, popcount
  - localparams for the error bit indices (ERR_UNDERFLOW=0, ERR_GRAY=1, ERR_OVERFLOW=2)
- Both this block and the write-side counter use gray_pkg.
- One sub-module: gray_sync, a SYNC_STAGES-deep multi-bit synchronizer with async active-high reset. It is reusable on the write side for gray_rd_out.
- Estimated RTL size: ~150-200 lines.

## Test plan
All scenarios use LENGTH=8, SYNC_STAGES=2.
- Reset: assert reset_diff mid-run -> all outputs 0 immediately, empty=1, error=0.
- Fill: gray_in = gray(1)..gray(5), one per cycle -> empty=0 three cycles after the first change; count=5 three cycles after the last change.
- Drain and underflow: after the fill, hold rd_en for 6 cycles -> five rd_ack pulses; gray_rd_out=0x07; rd_addr=5; empty=1. The sixth request gets no ack and sets error[0]=1.
- Wrap: rd_bin at 250, gray_in stepped to gray(4) via 251..255,0..4 -> count=10, empty=0. Ten pops -> rd_addr=4, empty=1, error=0.
- Gray jump: gray_in 0x00->0x03 in one step -> error[1]=1 after the third edge and stays set until reset.
- Overflow: read pointer at 0, gray_in stepped to gray(129) -> count=129, error[2]=1.
